// File: rtl/jk_run_len.sv
// jk_run_len: run-length meter for a JK flip-flop output.
//
// Counts consecutive enabled cycles during which i_q holds one level. Each
// closed run is queued as a (level, length) record in a small FIFO.
//
// Optional build macro: RUN_LEN_SAT_EN
//   defined   -> the length saturates at 2^LEN_W-1 until the run closes
//   undefined -> a run that reaches 2^LEN_W-1 is split: the full record is
//                emitted and counting restarts at 1 on the same level
//
// Ports:
//   i_c          clock; all state updates on the rising edge
//   i_r          asynchronous active-low reset
//   i_q          flip-flop output under measurement (same clock domain)
//   i_en         sample enable; low pauses the open run
//   i_flush      close the open run now (this cycle's sample is not counted)
//   o_out_valid  head record available
//   i_out_ready  consumer accepts the head record
//   o_out_level  level of the head record (0 when empty)
//   o_out_len    length of the head record (0 when empty)
//   o_ovf        sticky: a record was dropped because the FIFO was full
//   o_fifo_cnt   records currently held
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | no open run; first enabled sample opens one
// S_RUN  | run open on r_cur_level, r_len samples so far

module jk_run_len #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic                   i_c,
  input  logic                   i_r,
  input  logic                   i_q,
  input  logic                   i_en,
  input  logic                   i_flush,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic                   o_out_level,
  output logic [LEN_W-1:0]       o_out_len,
  output logic                   o_ovf,
  output logic [$clog2(DEPTH):0] o_fifo_cnt
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_MAX  = '1;
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_cur_level;
  logic             w_cur_level_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_nxt;

  logic             w_push;
  logic             w_push_level;
  logic [LEN_W-1:0] w_push_len;

  logic             r_mem_level [DEPTH];
  logic [LEN_W-1:0] r_mem_len   [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic             r_ovf;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;

  // ---------------- run FSM: state register ----------------
  always_ff @(posedge i_c or negedge i_r) begin
    if (!i_r) begin
      r_state     <= S_IDLE;
      r_cur_level <= 1'b0;
      r_len       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_level <= w_cur_level_nxt;
      r_len       <= w_len_nxt;
    end
  end

  // ---------------- run FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_en)    w_state_nxt = S_RUN;   // flush is ignored while idle
      S_RUN:   if (i_flush) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- run FSM: outputs (record push + run datapath) ----------------
  always_comb begin
    w_push          = 1'b0;
    w_push_level    = r_cur_level;
    w_push_len      = r_len;
    w_cur_level_nxt = r_cur_level;
    w_len_nxt       = r_len;
    case (r_state)
      S_IDLE: begin
        if (i_en) begin
          w_cur_level_nxt = i_q;
          w_len_nxt       = LEN_ONE;
        end
      end
      S_RUN: begin
        if (i_flush) begin
          w_push          = 1'b1;
          w_cur_level_nxt = 1'b0;
          w_len_nxt       = '0;
        end else if (i_en) begin
          if (i_q != r_cur_level) begin
            w_push          = 1'b1;
            w_cur_level_nxt = i_q;
            w_len_nxt       = LEN_ONE;
          end else if (r_len == LEN_MAX) begin
`ifdef RUN_LEN_SAT_EN
            w_len_nxt = r_len;
`else
            // Counter would wrap: emit the full chunk and keep counting the
            // same level as a fresh run.
            w_push    = 1'b1;
            w_len_nxt = LEN_ONE;
`endif
          end else begin
            w_len_nxt = r_len + LEN_ONE;
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------- record FIFO ----------------
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == FULL_CNT);
  assign w_pop   = !w_empty && i_out_ready;
  // A simultaneous pop frees the head slot, so a push on a full FIFO still lands.
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge i_c) begin
    if (w_wr) begin
      r_mem_level[r_wr_ptr] <= w_push_level;
      r_mem_len[r_wr_ptr]   <= w_push_len;
    end
  end

  always_ff @(posedge i_c or negedge i_r) begin
    if (!i_r) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_push && !w_wr) r_ovf <= 1'b1;
    end
  end

  assign o_out_valid = !w_empty;
  assign o_out_level = w_empty ? 1'b0 : r_mem_level[r_rd_ptr];
  assign o_out_len   = w_empty ? '0   : r_mem_len[r_rd_ptr];
  assign o_ovf       = r_ovf;
  assign o_fifo_cnt  = r_cnt;

endmodule

// File: doc/jk_run_len.md
JK_RUN_LEN -- requirements
Module: jk_run_len

Interface
REQ-001 Parameter DEPTH, default 4, record FIFO entries (power of two, 2..16).
REQ-002 Parameter LEN_W, default 8, run-length field width.
REQ-003 c  input  1  clock; all state updates on rising edge.
REQ-004 r  input  1  reset; asynchronous and active-low.
REQ-005 q  input  1  JK flip-flop output under measurement, same clock domain, no synchroniser.
REQ-006 en  input  1  sample enable; when low, run measurement paused.
REQ-007 flush  input  1  close current run and emit it immediately.
REQ-008 out_valid  output  1  head record available.
REQ-009 out_ready  input  1  consumer accepts head record.
REQ-010 out_level  output  1  q level of head record.
REQ-011 out_len  output  LEN_W  cycle count of head record.
REQ-012 ovf  output  1  sticky: a record was dropped on a full FIFO.
REQ-013 fifo_cnt  output  clog2(DEPTH)+1  records currently held.

Function
REQ-014 Block SHALL measure consecutive enabled cycles q holds one level and emit (level, length) records.
REQ-015 States SHALL be IDLE (no open run) and RUN (open run with cur_level, len).
REQ-016 IDLE, en=1: capture cur_level=q, len=1, go RUN; en=0: stay IDLE.
REQ-017 RUN, en=1, flush=0, q==cur_level: len+1, subject to REQ-028/029.
REQ-018 RUN, en=1, flush=0, q!=cur_level: push (cur_level, len); cur_level=q, len=1; stay RUN.
REQ-019 RUN, en=0, flush=0: cur_level, len and state held; q ignored.
REQ-020 RUN, flush=1 (any en, any q): push (cur_level, len) excluding this cycle's sample; go IDLE.
REQ-021 IDLE, flush=1: no record; flush ignored; en=1 still starts a run per REQ-016.
REQ-022 Push at edge N; out_valid high from edge N when FIFO was empty (1-cycle latency from sampling q).
REQ-023 Pop when out_valid && out_ready at an edge; out_level/out_len hold stable while out_valid=1 and out_ready=0.
REQ-024 Push and pop at same edge SHALL both occur, including when FIFO full; fifo_cnt unchanged.
REQ-025 Push on full FIFO without pop: record dropped, FIFO unchanged, ovf set at that edge, held until reset.
REQ-026 Records SHALL be delivered in emission order; pointers wrap modulo DEPTH.
REQ-027 out_level/out_len SHALL be 0 when out_valid=0.

Reset
REQ-030 r low SHALL immediately force: state IDLE, len=0, cur_level=0, FIFO empty, fifo_cnt=0, out_valid=0, out_level=0, out_len=0, ovf=0.
REQ-031 Reset mid-run SHALL discard the open run and all queued records, no record emitted.
REQ-032 First run after r rises starts per REQ-016 at first edge with en=1.

Configuration
REQ-028 Macro RUN_LEN_SAT_EN defined: len saturates at 2^LEN_W-1; further equal samples leave len unchanged; record emitted on change/flush carries saturated value.
REQ-029 RUN_LEN_SAT_EN undefined: when len==2^LEN_W-1 and equal sample arrives, push (cur_level, 2^LEN_W-1) and restart len=1 same level (split runs).

Verification
REQ-033 Reset, en=1, q: 0 x3 cycles then 1 -> record (0,3), out_valid one cycle after q=1 sampled, fifo_cnt=1.
REQ-034 out_ready=0, q toggles each cycle x6 (DEPTH=4) -> records (0,1),(1,1),(0,1),(1,1) held, ovf=1 after 5th emission, fifo_cnt=4; then out_ready=1 -> four records drained in order, ovf stays 1.
REQ-035 q=1 for 4 cycles, en=0 for 3 cycles with q toggling, en=1 with q=1 for 2 more, then q=0 -> single record (1,6).
REQ-036 q=1 steady 300 cycles then 0, LEN_W=8 -> without macro (1,255),(1,45); with RUN_LEN_SAT_EN (1,255).
REQ-037 Run (0,5) open, flush=1 with q=1 -> record (0,5), state IDLE, next en=1 cycle opens run level 1 len=1.
REQ-038 FIFO full, out_ready=1 and new record same edge -> fifo_cnt stays 4, ovf stays 0; r pulsed low mid-run -> all outputs 0 asynchronously.
